// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit.
// State encoding, iteration count and small operand helpers.
package mult_div_unit_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MULT = 2'b01;
    localparam logic [1:0] ST_DIV  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    localparam int ITERATIONS = 32;

    function automatic word_t mag32(input word_t v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the control unit and the mult/div unit.
// The control unit drives operands and starts; the unit returns results.
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    word_t A;
    word_t B;
    logic  MultStart;
    logic  DivStart;
    logic  Busy;
    logic  Done;
    word_t Hi;
    word_t Lo;
    logic  DivZero;

    modport master (
        output A, B, MultStart, DivStart,
        input  Busy, Done, Hi, Lo, DivZero
    );

    modport slave (
        input  A, B, MultStart, DivStart,
        output Busy, Done, Hi, Lo, DivZero
    );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and restoring divide.
// Both share one 65-bit working register and a 5-bit step counter.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input logic            Clock,
    input logic            Reset,
    mult_div_unit_if.slave bus
);

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [64:0] work;
    word_t       opa;
    word_t       opb;
    word_t       hi_q;
    word_t       lo_q;
    logic        divzero_q;

    logic        accept;
    logic        last;
    logic [32:0] sum;
    logic [32:0] trial;
    word_t       shrem;
    word_t       dmag;
    logic [64:0] nxt;
    word_t       res_hi;
    word_t       res_lo;

    // Starts are only looked at while not iterating; multiply wins.
    assign accept = ((state == ST_IDLE) || (state == ST_DONE)) &&
                    (bus.MultStart || bus.DivStart);
    assign last   = (cnt == 5'(ITERATIONS - 1));
    assign dmag   = mag32(opb);
    assign shrem  = {work[62:32], work[31]};

    // One Booth or restoring step, plus the signed result it would give.
    always_comb begin
        sum    = 33'd0;
        trial  = 33'd0;
        nxt    = work;
        res_hi = hi_q;
        res_lo = lo_q;
        if (state == ST_MULT) begin
            case (work[1:0])
                2'b01:   sum = {work[64], work[64:33]} + {opa[31], opa};
                2'b10:   sum = {work[64], work[64:33]} - {opa[31], opa};
                default: sum = {work[64], work[64:33]};
            endcase
            nxt    = {sum[32:1], sum[0], work[32:2], work[1]};
            res_hi = nxt[64:33];
            res_lo = nxt[32:1];
        end else if (state == ST_DIV) begin
            trial = {1'b0, shrem} - {1'b0, dmag};
            if (!trial[32])
                nxt = {1'b0, trial[31:0], work[30:0], 1'b1};
            else
                nxt = {1'b0, shrem, work[30:0], 1'b0};
            res_lo = (opa[31] ^ opb[31]) ? -nxt[31:0] : nxt[31:0];
            res_hi = opa[31] ? -nxt[63:32] : nxt[63:32];
        end
    end

    // Sequencing: accept a start, iterate 32 steps, publish, pulse Done.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            work      <= '0;
            opa       <= '0;
            opb       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (accept) begin
                        opa       <= bus.A;
                        opb       <= bus.B;
                        cnt       <= '0;
                        divzero_q <= 1'b0;
                        if (bus.MultStart) begin
                            state <= ST_MULT;
                            work  <= {32'd0, bus.B, 1'b0};
                        end else if (bus.B == '0) begin
                            state     <= ST_DONE;
                            divzero_q <= 1'b1;
                        end else begin
                            state <= ST_DIV;
                            work  <= {33'd0, mag32(bus.A)};
                        end
                    end
                end
                ST_MULT, ST_DIV: begin
                    work <= nxt;
                    cnt  <= cnt + 5'd1;
                    if (last) begin
                        state <= ST_DONE;
                        hi_q  <= res_hi;
                        lo_q  <= res_lo;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Busy    = (state == ST_MULT) || (state == ST_DIV);
    assign bus.Done    = (state == ST_DONE);
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
    assign bus.DivZero = divzero_q;

endmodule
